// File: rtl/barrel_shift_pkg.sv
// Shared mode encoding for the pipelined barrel shifter.
// Modes 5-7 are reserved and pass the operand through unshifted.
package barrel_shift_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_SLL = 3'd0;
    localparam mode_t MODE_SRL = 3'd1;
    localparam mode_t MODE_SRA = 3'd2;
    localparam mode_t MODE_ROL = 3'd3;
    localparam mode_t MODE_ROR = 3'd4;

endpackage

// File: rtl/shift_stage.sv
// One pipeline level: conditionally shifts by SHIFT when the matching amt bit is set,
// then registers valid/data/mode/amt whenever the stage is empty or downstream loads.
module shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  mode_t            up_mode,
    input  logic [AMT_W-1:0] up_amt,
    input  logic             down_ready,
    output logic             load,
    output logic [WIDTH-1:0] data_nxt,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output mode_t            mode,
    output logic [AMT_W-1:0] amt
);

    logic hit;

    assign hit  = |(up_amt & AMT_W'(SHIFT));
    assign load = !valid || down_ready;

    // SRA replicates the incoming MSB; earlier SRA levels have already sign-extended it.
    always_comb begin
        data_nxt = up_data;
        if (hit) begin
            case (up_mode)
                MODE_SLL: data_nxt = {up_data[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
                MODE_SRL: data_nxt = {{SHIFT{1'b0}}, up_data[WIDTH-1:SHIFT]};
                MODE_SRA: data_nxt = {{SHIFT{up_data[WIDTH-1]}}, up_data[WIDTH-1:SHIFT]};
                MODE_ROL: data_nxt = {up_data[WIDTH-1-SHIFT:0], up_data[WIDTH-1:WIDTH-SHIFT]};
                MODE_ROR: data_nxt = {up_data[SHIFT-1:0], up_data[WIDTH-1:SHIFT]};
                default:  data_nxt = up_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= '0;
            amt   <= '0;
        end else if (load) begin
            valid <= up_valid;
            data  <= data_nxt;
            mode  <= up_mode;
            amt   <= up_amt;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: one shift level per stage, valid/ready on both
// sides, and empty stages refill even while the output is stalled.
module pipelined_barrel_shifter
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    logic [AMT_W:0]                  valid_s;
    logic [AMT_W:0][WIDTH-1:0]       data_s;
    logic [AMT_W:0][MODE_W-1:0]      mode_s;
    logic [AMT_W:0][AMT_W-1:0]       amt_s;
    logic [AMT_W-1:0][WIDTH-1:0]     nxt_s;
    logic [AMT_W-1:0]                load_s;
    logic [AMT_W-1:0]                down_rdy;
    logic                            rdy_acc;
    logic                            zero_q;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign mode_s[0]  = in_mode;
    assign amt_s[0]   = in_amt;

    // Ready chain built from stage valids only, so no stage's load feeds back into itself.
    always_comb begin
        down_rdy = '0;
        rdy_acc  = out_ready;
        for (int k = AMT_W - 1; k >= 0; k--) begin
            down_rdy[k] = rdy_acc;
            rdy_acc     = rdy_acc || !valid_s[k+1];
        end
    end

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .up_valid   (valid_s[k]),
            .up_data    (data_s[k]),
            .up_mode    (mode_s[k]),
            .up_amt     (amt_s[k]),
            .down_ready (down_rdy[k]),
            .load       (load_s[k]),
            .data_nxt   (nxt_s[k]),
            .valid      (valid_s[k+1]),
            .data       (data_s[k+1]),
            .mode       (mode_s[k+1]),
            .amt        (amt_s[k+1])
        );
    end

    // Zero flag is resolved before the last register so it lines up with out_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
        end else if (load_s[AMT_W-1]) begin
            zero_q <= valid_s[AMT_W-1] && (nxt_s[AMT_W-1] == '0);
        end
    end

    assign in_ready  = load_s[0];
    assign out_valid = valid_s[AMT_W];
    assign out_data  = data_s[AMT_W];
    assign out_zero  = zero_q;

    logic unused_tail;
    assign unused_tail = ^{mode_s[AMT_W], amt_s[AMT_W], nxt_s, load_s};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH 8, 16 and 32.
// Drivers push expected results on acceptance; per-width monitors pop on each output transfer.
module tb_pipelined_barrel_shifter;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string info);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, info);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int W = 8 << g;
        localparam int A = $clog2(W);

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] in_data;
        logic [A-1:0] in_amt;
        logic [2:0]   in_mode;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] out_data;
        logic         out_zero;

        logic [W-1:0] exp_q[$];
        bit           done = 1'b0;
        bit           stall_prev = 1'b0;
        logic [W-1:0] held;

        pipelined_barrel_shifter #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_amt    (in_amt),
            .in_mode   (in_mode),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_zero  (out_zero)
        );

        function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt, input int mode);
            case (mode)
                0: return d << amt;
                1: return d >> amt;
                2: return W'($signed(d) >>> amt);
                3: return (d << amt) | (d >> (W - amt));
                4: return (d >> amt) | (d << (W - amt));
                default: return d;
            endcase
        endfunction

        // Monitor: sampled 2 time units after the falling edge, well clear of posedge.
        always @(negedge clk) begin
            logic [W-1:0] e;
            #2;
            if (rst_n) begin
                if (stall_prev) begin
                    check($sformatf("w%0d_stall_valid", W), 64'(out_valid), 64'(1));
                    check($sformatf("w%0d_stall_data", W), 64'(out_data), 64'(held));
                end
                stall_prev = out_valid && !out_ready;
                held = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail($sformatf("w%0d_unexpected_output", W), $sformatf("got %0h with empty scoreboard", out_data));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("w%0d_data", W), 64'(out_data), 64'(e));
                        check($sformatf("w%0d_zero", W), 64'(out_zero), 64'(e == '0));
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end

        // Presents one op (called at a falling edge), holds it until accepted, pushes the expectation.
        task automatic send(input logic [W-1:0] d, input int amt, input int mode,
                            input logic [W-1:0] exp, input bit rnd);
            int n = 0;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_data  = d;
            in_amt   = A'(amt);
            in_mode  = 3'(mode);
            #1;
            while (!in_ready) begin
                n++;
                if (n > 200) begin
                    fail($sformatf("w%0d_send_timeout", W), "in_ready never rose");
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
                if (rnd) out_ready = 1'($urandom_range(0, 1));
                #1;
            end
            exp_q.push_back(exp);
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        task automatic drain();
            int n = 0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0)
                fail($sformatf("w%0d_drain_timeout", W), $sformatf("%0d results missing", exp_q.size()));
            @(negedge clk);
        endtask

        task automatic random_phase(input int n_ops);
            logic [W-1:0] d;
            int amt;
            int mode;
            for (int i = 0; i < n_ops; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    d    = W'($urandom);
                    amt  = $urandom_range(0, W - 1);
                    mode = $urandom_range(0, 7);
                    send(d, amt, mode, model(d, amt, mode), 1'b1);
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            drain();
        endtask

        task automatic start_reset();
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            in_data   = '0;
            in_amt    = '0;
            in_mode   = '0;
            out_ready = 1'b0;
            repeat (2) @(negedge clk);
        endtask

        if (g == 0) begin : g_seq
            task automatic single(input logic [W-1:0] d, input int amt, input int mode,
                                  input logic [W-1:0] exp, input string name);
                int n;
                out_ready = 1'b1;
                send(d, amt, mode, exp, 1'b0);
                n = 1;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check({name, "_latency"}, 64'(n), 64'(A));
                @(negedge clk);
            endtask

            initial begin
                logic [W-1:0] d;
                int amt;
                int mode;
                int acc;

                start_reset();
                check("reset_out_valid", 64'(out_valid), 64'(0));
                check("reset_out_data", 64'(out_data), 64'(0));
                check("reset_out_zero", 64'(out_zero), 64'(0));
                check("reset_in_ready", 64'(in_ready), 64'(1));
                rst_n = 1'b1;
                @(negedge clk);

                single(8'hB4, 3, 0, 8'hA0, "sll_b4");
                single(8'hB4, 3, 1, 8'h16, "srl_b4");
                single(8'hB4, 3, 2, 8'hF6, "sra_b4");
                single(8'hB4, 3, 3, 8'hA5, "rol_b4");
                single(8'hB4, 3, 4, 8'h96, "ror_b4");
                single(8'hB4, 3, 6, 8'hB4, "rsvd_b4");
                for (int m = 0; m < 8; m++) begin
                    d = W'($urandom);
                    single(d, 0, m, d, $sformatf("amt0_m%0d", m));
                end
                single(8'h80, 7, 2, 8'hFF, "sra_80_7");
                single(8'h01, 7, 0, 8'h80, "sll_01_7");
                single(8'h80, 1, 0, 8'h00, "sll_80_1");

                // Back-to-back streaming
                out_ready = 1'b1;
                for (int i = 0; i < 100; i++) begin
                    d    = W'($urandom);
                    amt  = $urandom_range(0, W - 1);
                    mode = $urandom_range(0, 7);
                    in_valid = 1'b1;
                    in_data  = d;
                    in_amt   = A'(amt);
                    in_mode  = 3'(mode);
                    #1;
                    check("stream_in_ready", 64'(in_ready), 64'(1));
                    if (i >= A) check("stream_out_valid", 64'(out_valid), 64'(1));
                    exp_q.push_back(model(d, amt, mode));
                    @(negedge clk);
                end
                drain();

                // Backpressure: pipeline holds exactly A entries
                out_ready = 1'b0;
                acc = 0;
                d = W'($urandom); amt = $urandom_range(0, W - 1); mode = $urandom_range(0, 7);
                in_valid = 1'b1; in_data = d; in_amt = A'(amt); in_mode = 3'(mode);
                for (int i = 0; i < 8; i++) begin
                    #1;
                    if (in_ready) begin
                        exp_q.push_back(model(d, amt, mode));
                        acc++;
                        @(negedge clk);
                        d = W'($urandom); amt = $urandom_range(0, W - 1); mode = $urandom_range(0, 7);
                        in_data = d; in_amt = A'(amt); in_mode = 3'(mode);
                    end else begin
                        @(negedge clk);
                    end
                end
                check("bp_accept_count", 64'(acc), 64'(A));
                #1;
                check("bp_full_in_ready", 64'(in_ready), 64'(0));
                out_ready = 1'b1;
                #1;
                check("bp_pop_push_in_ready", 64'(in_ready), 64'(1));
                exp_q.push_back(model(d, amt, mode));
                @(negedge clk);
                out_ready = 1'b0;
                d = W'($urandom); amt = $urandom_range(0, W - 1); mode = $urandom_range(0, 7);
                in_data = d; in_amt = A'(amt); in_mode = 3'(mode);
                #1;
                check("bp_refull_in_ready", 64'(in_ready), 64'(0));
                in_valid = 1'b0;
                drain();

                // Reset with three ops in flight
                out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    d = W'($urandom);
                    send(d, 1, 3, model(d, 1, 3), 1'b0);
                end
                rst_n = 1'b0;
                exp_q.delete();
                #1;
                check("midreset_out_valid", 64'(out_valid), 64'(0));
                check("midreset_out_data", 64'(out_data), 64'(0));
                check("midreset_out_zero", 64'(out_zero), 64'(0));
                check("midreset_in_ready", 64'(in_ready), 64'(1));
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (10) @(negedge clk);
                check("postreset_out_valid", 64'(out_valid), 64'(0));
                check("postreset_in_ready", 64'(in_ready), 64'(1));

                random_phase(300);
                done = 1'b1;
            end
        end else begin : g_seq
            initial begin
                start_reset();
                rst_n = 1'b1;
                @(negedge clk);
                random_phase(300);
                done = 1'b1;
            end
        end
    end

    initial begin
        int t = 0;
        while (!(g_w[0].done && g_w[1].done && g_w[2].done) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60000) fail("global_timeout", "test sequences did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
